// File: rtl/axi_rd_burst_ctrl_pkg.sv
// Shared definitions for the AXI4 read-burst controller: burst encoding,
// controller state type and the AR size helper.
package axi_rd_burst_ctrl_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } rd_state_t;

  // AXI arsize encodes log2 of the beat width in the same units as the DQ width.
  function automatic logic [2:0] calc_arsize(input int unsigned dq_width);
    return 3'($clog2(dq_width));
  endfunction

endpackage

// File: rtl/axi_rd_burst_ctrl.sv
// AXI4 read master: issues one INCR burst per request, streams R beats to a
// ping-pong consumer pair and reports burst/command completion.
module axi_rd_burst_ctrl
  import axi_rd_burst_ctrl_pkg::*;
#(
  parameter int unsigned CTRL_ADDR_WIDTH = 28,
  parameter int unsigned MEM_DQ_WIDTH    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [CTRL_ADDR_WIDTH-1:0]   read_addr,
  input  logic [3:0]                   read_id,
  input  logic [3:0]                   read_len,
  input  logic                         read_en,
  output logic                         read_done_p,
  input  logic                         read_ready,
  output logic [MEM_DQ_WIDTH*8-1:0]    read_rdata,
  output logic                         read_rdata_en1,
  output logic                         read_rdata_en2,
  input  logic                         read_done,
  output logic                         read_cmd_en_p,
  output logic [CTRL_ADDR_WIDTH-1:0]   axi_araddr,
  output logic [3:0]                   axi_arid,
  output logic [3:0]                   axi_arlen,
  output logic [2:0]                   axi_arsize,
  output logic [1:0]                   axi_arburst,
  output logic                         axi_arvalid,
  input  logic                         axi_arready,
  output logic                         axi_rready,
  input  logic [MEM_DQ_WIDTH*8-1:0]    axi_rdata,
  input  logic                         axi_rvalid,
  input  logic                         axi_rlast,
  input  logic [3:0]                   axi_rid,
  input  logic [1:0]                   axi_rresp,
  output logic                         flag
);

  rd_state_t state, state_next;
  logic      load_ar;
  logic      beat;
  logic      unused_rsp;

  assign unused_rsp = ^{axi_rid, axi_rresp};

  assign axi_arsize  = calc_arsize(MEM_DQ_WIDTH);
  assign axi_arburst = AXI_BURST_INCR;

  // Beat gating is deliberately not state-qualified: stray beats still reach the consumer.
  assign axi_rready     = read_ready;
  assign read_rdata     = axi_rdata;
  assign beat           = axi_rvalid & read_ready;
  assign read_rdata_en1 = beat & ~flag;
  assign read_rdata_en2 = beat & flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_ar    = 1'b0;
    case (state)
      IDLE: begin
        if (read_en) begin
          state_next = ADDR;
          load_ar    = 1'b1;
        end
      end
      ADDR: begin
        if (axi_arvalid && axi_arready) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (beat && axi_rlast) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // arvalid and read_done_p are registered decodes of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      axi_araddr    <= '0;
      axi_arid      <= '0;
      axi_arlen     <= '0;
      axi_arvalid   <= 1'b0;
      read_done_p   <= 1'b0;
      read_cmd_en_p <= 1'b0;
      flag          <= 1'b0;
    end else begin
      if (load_ar) begin
        axi_araddr <= read_addr;
        axi_arid   <= read_id;
        axi_arlen  <= read_len;
      end
      axi_arvalid   <= (state_next == ADDR);
      read_done_p   <= (state_next == DONE);
      read_cmd_en_p <= read_done;
      if (read_done) begin
        flag <= ~flag;
      end
    end
  end

endmodule

// File: tb/tb_axi_rd_burst_ctrl.sv
// Self-checking bench for axi_rd_burst_ctrl: AR issue/hold, R streaming
// through a scoreboard, ping-pong select and reset behaviour.
module tb_axi_rd_burst_ctrl;

  localparam int AW = 28;
  localparam int DQ = 16;
  localparam int DW = DQ * 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] read_addr;
  logic [3:0]    read_id;
  logic [3:0]    read_len;
  logic          read_en;
  logic          read_done_p;
  logic          read_ready;
  logic [DW-1:0] read_rdata;
  logic          read_rdata_en1;
  logic          read_rdata_en2;
  logic          read_done;
  logic          read_cmd_en_p;
  logic [AW-1:0] axi_araddr;
  logic [3:0]    axi_arid;
  logic [3:0]    axi_arlen;
  logic [2:0]    axi_arsize;
  logic [1:0]    axi_arburst;
  logic          axi_arvalid;
  logic          axi_arready;
  logic          axi_rready;
  logic [DW-1:0] axi_rdata;
  logic          axi_rvalid;
  logic          axi_rlast;
  logic [3:0]    axi_rid;
  logic [1:0]    axi_rresp;
  logic          flag;

  typedef struct {
    logic [DW-1:0] data;
    logic          buf_sel;
  } beat_t;

  beat_t sb[$];
  beat_t exp_beat;
  int    tests = 0;
  int    fails = 0;
  int    beats_seen;
  logic  exp_flag;

  always #5 clk = ~clk;

  axi_rd_burst_ctrl #(
    .CTRL_ADDR_WIDTH(AW),
    .MEM_DQ_WIDTH   (DQ)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .read_addr     (read_addr),
    .read_id       (read_id),
    .read_len      (read_len),
    .read_en       (read_en),
    .read_done_p   (read_done_p),
    .read_ready    (read_ready),
    .read_rdata    (read_rdata),
    .read_rdata_en1(read_rdata_en1),
    .read_rdata_en2(read_rdata_en2),
    .read_done     (read_done),
    .read_cmd_en_p (read_cmd_en_p),
    .axi_araddr    (axi_araddr),
    .axi_arid      (axi_arid),
    .axi_arlen     (axi_arlen),
    .axi_arsize    (axi_arsize),
    .axi_arburst   (axi_arburst),
    .axi_arvalid   (axi_arvalid),
    .axi_arready   (axi_arready),
    .axi_rready    (axi_rready),
    .axi_rdata     (axi_rdata),
    .axi_rvalid    (axi_rvalid),
    .axi_rlast     (axi_rlast),
    .axi_rid       (axi_rid),
    .axi_rresp     (axi_rresp),
    .flag          (flag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; read_addr = '0; read_id = '0; read_len = '0; read_en = 1'b0;
    read_ready = 1'b1; read_done = 1'b0; axi_arready = 1'b0; axi_rdata = '0;
    axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rid = 4'h5; axi_rresp = 2'b10;
    exp_flag = 1'b0;
    tick(); tick();
    tests++;
    if ({axi_arvalid, axi_araddr, axi_arid, axi_arlen, read_done_p, read_cmd_en_p, flag} !== '0) begin
      fails++;
      $display("FAIL reset_regs: got arvalid=%b araddr=%h arid=%h arlen=%h done_p=%b cmd_en_p=%b flag=%b, want all 0",
               axi_arvalid, axi_araddr, axi_arid, axi_arlen, read_done_p, read_cmd_en_p, flag);
    end
    tests++;
    if (axi_arsize !== 3'b100 || axi_arburst !== 2'b01) begin
      fails++;
      $display("FAIL ar_consts: got arsize=%b arburst=%b, want 100/01", axi_arsize, axi_arburst);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic issue_cmd(input logic [AW-1:0] addr, input logic [3:0] id, input logic [3:0] len,
                           input int ar_wait, input bit poke);
    read_addr = addr; read_id = id; read_len = len; read_en = 1'b1;
    axi_arready = (ar_wait == 0);
    tick();
    read_en = 1'b0;
    read_addr = AW'($urandom); read_id = 4'($urandom); read_len = 4'($urandom);
    tests++;
    if ({axi_arvalid, axi_araddr, axi_arid, axi_arlen} !== {1'b1, addr, id, len}) begin
      fails++;
      $display("FAIL ar_issue: got v=%b a=%h id=%h len=%h, want v=1 a=%h id=%h len=%h",
               axi_arvalid, axi_araddr, axi_arid, axi_arlen, addr, id, len);
    end
    for (int i = 0; i < ar_wait; i++) begin
      read_en = poke && (i == 1);
      tick();
      read_en = 1'b0;
      tests++;
      if ({axi_arvalid, axi_araddr, axi_arid, axi_arlen} !== {1'b1, addr, id, len}) begin
        fails++;
        $display("FAIL ar_hold: cycle %0d got v=%b a=%h id=%h len=%h, want v=1 a=%h id=%h len=%h",
                 i, axi_arvalid, axi_araddr, axi_arid, axi_arlen, addr, id, len);
      end
    end
    axi_arready = 1'b1;
    tick();
    axi_arready = 1'b0;
    tests++;
    if (axi_arvalid !== 1'b0) begin
      fails++;
      $display("FAIL ar_drop: got arvalid=%b after handshake, want 0", axi_arvalid);
    end
  endtask

  // mode 0: continuous beats and ready; mode 1: ready toggles, rvalid has gaps.
  task automatic run_burst(input logic [3:0] len, input int mode, input bit done_with_last, input bit poke);
    int   sent = 0;
    int   cyc = 0;
    bit   pending = 0;
    bit   last = 0;
    beats_seen = 0;
    while (sent <= int'(len)) begin
      if (!pending) begin
        pending = (mode == 0) || (cyc % 3 != 2);
        if (pending) begin
          axi_rdata = {$urandom, $urandom, $urandom, $urandom};
          last = (sent == int'(len));
        end
      end
      axi_rvalid = pending;
      axi_rlast  = pending && last;
      read_ready = (mode == 0) || (cyc % 2 == 0);
      read_done  = done_with_last && axi_rlast && read_ready;
      read_en    = poke && (cyc == 1);
      #1;
      tests++;
      if (axi_rready !== read_ready || read_rdata !== axi_rdata) begin
        fails++;
        $display("FAIL passthru: got rready=%b rdata=%h, want %b %h", axi_rready, read_rdata, read_ready, axi_rdata);
      end
      if (pending && read_ready) begin
        sb.push_back('{data: axi_rdata, buf_sel: exp_flag});
        sent++;
        pending = 0;
      end
      @(negedge clk);
      tests++;
      if (read_done_p !== 1'b0) begin
        fails++;
        $display("FAIL done_early: got read_done_p=%b mid-burst, want 0", read_done_p);
      end
      if (read_rdata_en1 || read_rdata_en2) begin
        beats_seen++;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got en1=%b en2=%b, want no strobe", read_rdata_en1, read_rdata_en2);
        end else begin
          exp_beat = sb.pop_front();
          if (read_rdata !== exp_beat.data ||
              {read_rdata_en2, read_rdata_en1} !== (exp_beat.buf_sel ? 2'b10 : 2'b01)) begin
            fails++;
            $display("FAIL beat: got en2/en1=%b%b data=%h, want buf%0d data=%h",
                     read_rdata_en2, read_rdata_en1, read_rdata, exp_beat.buf_sel, exp_beat.data);
          end
        end
      end
      @(posedge clk);
      #1;
      if (read_done) exp_flag = ~exp_flag;
      cyc++;
    end
    axi_rvalid = 1'b0; axi_rlast = 1'b0; read_done = 1'b0; read_en = 1'b0; read_ready = 1'b1;
    tests++;
    if (read_done_p !== 1'b1) begin
      fails++;
      $display("FAIL done_pulse: got read_done_p=%b after rlast beat, want 1", read_done_p);
    end
    if (done_with_last) begin
      tests++;
      if (flag !== exp_flag || read_cmd_en_p !== 1'b1) begin
        fails++;
        $display("FAIL done_with_last: got flag=%b cmd_en_p=%b, want %b 1", flag, read_cmd_en_p, exp_flag);
      end
    end
    tick();
    tests++;
    if (read_done_p !== 1'b0 || axi_arvalid !== 1'b0) begin
      fails++;
      $display("FAIL done_end: got read_done_p=%b arvalid=%b, want 0 0", read_done_p, axi_arvalid);
    end
    tests++;
    if (sb.size() != 0 || beats_seen != int'(len) + 1) begin
      fails++;
      $display("FAIL beat_count: got %0d beats (%0d unseen), want %0d", beats_seen, sb.size(), int'(len) + 1);
      sb.delete();
    end
  endtask

  task automatic pulse_read_done();
    read_done = 1'b1;
    tick();
    read_done = 1'b0;
    exp_flag = ~exp_flag;
    tests++;
    if (flag !== exp_flag || read_cmd_en_p !== 1'b1) begin
      fails++;
      $display("FAIL pingpong: got flag=%b cmd_en_p=%b, want %b 1", flag, read_cmd_en_p, exp_flag);
    end
    tick();
    tests++;
    if (read_cmd_en_p !== 1'b0 || flag !== exp_flag) begin
      fails++;
      $display("FAIL cmd_en_width: got cmd_en_p=%b flag=%b, want 0 %b", read_cmd_en_p, flag, exp_flag);
    end
  endtask

  task automatic test_basic();
    issue_cmd(28'h100, 4'd3, 4'd7, 0, 0);
    run_burst(4'd7, 0, 0, 0);
  endtask

  task automatic test_ar_backpressure();
    issue_cmd(28'hABCDE0, 4'd5, 4'd3, 5, 1);
    run_burst(4'd3, 0, 0, 1);
  endtask

  task automatic test_r_backpressure();
    issue_cmd(28'h2000, 4'd1, 4'd9, 2, 0);
    run_burst(4'd9, 1, 0, 0);
  endtask

  task automatic test_pingpong();
    pulse_read_done();
    issue_cmd(28'h3000, 4'd2, 4'd4, 0, 0);
    run_burst(4'd4, 0, 0, 0);
    pulse_read_done();
    issue_cmd(28'h3400, 4'd6, 4'd5, 1, 0);
    run_burst(4'd5, 1, 1, 0);
  endtask

  task automatic test_back_to_back();
    issue_cmd(28'h5000, 4'd8, 4'd0, 0, 0);
    run_burst(4'd0, 0, 0, 0);
    issue_cmd(28'h5010, 4'd9, 4'd15, 0, 0);
    run_burst(4'd15, 0, 0, 0);
    issue_cmd(28'h5200, 4'd10, 4'd2, 0, 0);
    run_burst(4'd2, 1, 0, 0);
  endtask

  task automatic test_reset_mid();
    if (exp_flag == 1'b0) pulse_read_done();
    read_addr = 28'h777; read_id = 4'd4; read_len = 4'd3; read_en = 1'b1; axi_arready = 1'b0;
    tick();
    read_en = 1'b0;
    tick();
    tests++;
    if (axi_arvalid !== 1'b1 || flag !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset: got arvalid=%b flag=%b, want 1 1", axi_arvalid, flag);
    end
    #2 rst_n = 1'b0;
    #1;
    exp_flag = 1'b0;
    tests++;
    if ({axi_arvalid, flag, read_done_p, read_cmd_en_p, axi_araddr, axi_arid, axi_arlen} !== '0) begin
      fails++;
      $display("FAIL async_reset: got arvalid=%b flag=%b done_p=%b araddr=%h, want all 0",
               axi_arvalid, flag, read_done_p, axi_araddr);
    end
    tick();
    rst_n = 1'b1;
    tick();
    issue_cmd(28'h40, 4'd7, 4'd1, 0, 0);
    run_burst(4'd1, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ar_backpressure();
    test_r_backpressure();
    test_pingpong();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_rd_burst_ctrl.md
Name: axi_rd_burst_ctrl

Overview:
AXI4 read-channel master for the DDR frame-buffer path. It accepts single-burst read requests from the command translator, issues one INCR burst on AR, and streams R beats to one of two ping-pong consumers. It reports burst completion back to the translator. On each whole-command completion it flips the ping-pong buffer select and requests the next command.

Parameters:
CTRL_ADDR_WIDTH, 28, AXI byte-address width.
MEM_DQ_WIDTH, 16, DDR DQ width; AXI data bus is MEM_DQ_WIDTH*8 bits.

Ports:
clk  in  1  system clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
read_addr  in  CTRL_ADDR_WIDTH  burst start address; sampled when read_en=1.
read_id  in  4  AXI ID; sampled with read_addr.
read_len  in  4  AXI arlen (beats-1); sampled with read_addr.
read_en  in  1  one-cycle burst request.
read_done_p  out  1  one-cycle pulse when the burst's last beat is accepted.
read_ready  in  1  downstream ready to accept data.
read_rdata  out  MEM_DQ_WIDTH*8  read data, equal to axi_rdata.
read_rdata_en1  out  1  data strobe for buffer 0.
read_rdata_en2  out  1  data strobe for buffer 1.
read_done  in  1  one-cycle pulse: whole multi-burst command finished.
read_cmd_en_p  out  1  one-cycle pulse requesting the next read command.
axi_araddr  out  CTRL_ADDR_WIDTH  AR address.
axi_arid  out  4  AR ID.
axi_arlen  out  4  AR length.
axi_arsize  out  3  constant clog2(MEM_DQ_WIDTH) (16 -> 3'b100).
axi_arburst  out  2  constant 2'b01 (INCR).
axi_arvalid  out  1  AR valid.
axi_arready  in  1  AR ready.
axi_rready  out  1  R ready.
axi_rdata  in  MEM_DQ_WIDTH*8  R data.
axi_rvalid  in  1  R valid.
axi_rlast  in  1  R last.
axi_rid  in  4  R ID; ignored.
axi_rresp  in  2  R response; ignored.
flag  out  1  ping-pong select: 0 = buffer 0, 1 = buffer 1.

Behaviour:
- Reset values: all registered outputs are 0, including arvalid, araddr, arid, arlen, read_done_p, read_cmd_en_p and flag. State is IDLE.
- State machine, states IDLE, ADDR, DATA, DONE:
  - IDLE: when read_en=1, latch addr, id and len into the ax* registers, set arvalid=1, go to ADDR.
  - ADDR: hold arvalid and every AR field stable until arready. On the arvalid&arready cycle, drop arvalid next cycle and go to DATA. AR handshake latency is 1 cycle if arready is already high.
  - DATA: on rvalid&rready&rlast, go to DONE.
  - DONE: assert read_done_p for exactly 1 cycle, then return to IDLE.
- read_en is ignored in every state except IDLE; there is no queuing.
- Data path:
  - axi_rready = read_ready (combinational pass-through).
  - read_rdata = axi_rdata (combinational).
  - Beat accept b = axi_rvalid & read_ready.
  - read_rdata_en1 = b & ~flag; read_rdata_en2 = b & flag.
  - Beats arriving outside DATA are still forwarded; the beat gate is not state-qualified.
- Ping-pong:
  - read_done=1 toggles flag on the next edge.
  - read_cmd_en_p is a registered copy of read_done, i.e. a 1-cycle pulse 1 cycle after read_done.
- Simultaneous read_done and rlast: handled independently; the flag toggle takes effect for the following beats.
- Async reset mid-burst: return to IDLE and clear all registers immediately; any outstanding AXI beats are dropped by the interconnect reset.

Decomposition:
- Shared package: AXI_BURST_INCR=2'b01, the state enum, and a clog2-based arsize function.
- No sub-module; a single flat module is natural.

Test Plan:
- Reset: rst_n=0 mid-ADDR -> arvalid=0, flag=0, read_done_p=0 immediately; state IDLE after release.
- Basic burst: read_en with addr=0x100, id=3, len=7, arready high -> arvalid for 1 cycle with araddr=0x100, arid=3, arlen=7, arsize=3'b100, arburst=01. Then 8 beats with read_ready=1 -> 8 read_rdata_en1 pulses, 0 read_rdata_en2 pulses, read_done_p one cycle after the rlast beat.
- AR backpressure: arready low for 5 cycles -> arvalid and all AR fields held constant; read_en pulses during this window are ignored.
- R backpressure: read_ready toggling -> rready follows it; strobes only on rvalid&ready cycles; beat count equals len+1.
- Ping-pong: read_done pulse -> flag=1 next cycle and read_cmd_en_p one cycle after read_done; the next burst's beats appear on read_rdata_en2. A second read_done returns flag to 0.
- Back-to-back: read_en in the cycle after read_done_p -> new burst accepted without loss.
